// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: a load scoreboard plus an outstanding-load counter. Each cycle it
// decides whether the decoded instruction issues, stalls on a hazard, or waits for loads to drain.
module id_issue_ctrl #(
  parameter int MAX_PEND = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  output logic             inst_ready,
  input  logic [4:0]       rs1_index,
  input  logic [4:0]       rs2_index,
  input  logic             rs1_en,
  input  logic             rs2_en,
  input  logic [4:0]       rd_index,
  input  logic             rd_en,
  input  logic             inst_load,
  input  logic             inst_csr,
  input  logic             inst_trap,
  input  logic             inst_mret,
  input  logic             ex_ready,
  output logic             issue_valid,
  input  logic             wb_valid,
  input  logic [4:0]       wb_index,
  input  logic             flush,
  output logic [31:0]      busy_map,
  output logic [2:0]       pend_cnt,
  output logic [1:0]       stall_cause,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             err_underflow,
  output logic [1:0]       fsm_state
);

  // Handshake: issue_valid presents the instruction to EX; a transfer happens in a cycle where
  // issue_valid and ex_ready are both high, which is exactly inst_ready. No registered stage.

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_HAZ = 2'd1, ST_DRAIN = 2'd2} state_t;

  localparam logic [2:0] MAX_P = 3'(MAX_PEND);

  state_t      state, state_next;
  logic [31:0] wb_mask, set_mask, busy_eff, busy_next;
  logic [2:0]  pend_eff, pend_next;
  logic        data_haz, full_haz, drain_haz, hazard, stalling;
  logic        load_issue, wb_dec;

  assign fsm_state = state;

  always_comb begin
    wb_mask    = 32'd0;
    set_mask   = 32'd0;
    busy_eff   = 32'd0;
    busy_next  = 32'd0;
    pend_eff   = pend_cnt;
    pend_next  = pend_cnt;
    data_haz   = 1'b0;
    full_haz   = 1'b0;
    drain_haz  = 1'b0;
    hazard     = 1'b0;
    stalling   = 1'b0;
    load_issue = 1'b0;
    wb_dec     = 1'b0;
    issue_valid = 1'b0;
    inst_ready  = 1'b0;
    stall_cause = 2'b00;

    // Write-back frees its register and load slot in the same cycle it completes.
    if (wb_valid && wb_index != 5'd0) wb_mask = 32'd1 << wb_index;
    busy_eff = busy_map & ~wb_mask;
    wb_dec   = wb_valid && (pend_cnt != 3'd0);
    pend_eff = wb_dec ? pend_cnt - 3'd1 : pend_cnt;

    data_haz  = (rs1_en && busy_eff[rs1_index]) || (rs2_en && busy_eff[rs2_index]) ||
                (rd_en && busy_eff[rd_index]);
    full_haz  = inst_load && (pend_eff == MAX_P);
    drain_haz = (inst_csr || inst_trap || inst_mret) && (pend_eff != 3'd0);
    hazard    = data_haz || full_haz || drain_haz;

    stalling    = rst && inst_valid && !flush;
    issue_valid = stalling && !hazard;
    inst_ready  = issue_valid && ex_ready;

    if (stalling) begin
      if (drain_haz)     stall_cause = 2'b10;
      else if (data_haz) stall_cause = 2'b01;
      else if (full_haz) stall_cause = 2'b11;
    end

    // A load issuing to rd wins over a same-cycle write-back clearing that rd.
    load_issue = inst_ready && inst_load;
    if (load_issue && rd_en && rd_index != 5'd0) set_mask = 32'd1 << rd_index;
    busy_next = busy_eff | set_mask;
    pend_next = pend_cnt + {2'b00, load_issue} - {2'b00, wb_dec};
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (inst_valid && !flush) begin
          if (drain_haz)                 state_next = ST_DRAIN;
          else if (data_haz || full_haz) state_next = ST_HAZ;
        end
      end
      ST_HAZ: begin
        if (flush || !inst_valid) state_next = ST_RUN;
        else if (drain_haz)       state_next = ST_DRAIN;
        else if (!hazard)         state_next = ST_RUN;
      end
      ST_DRAIN: begin
        if (flush || !inst_valid || pend_eff == 3'd0) state_next = ST_RUN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_RUN;
      busy_map      <= 32'd0;
      pend_cnt      <= 3'd0;
      stall_cycles  <= '0;
      err_underflow <= 1'b0;
    end else begin
      state    <= state_next;
      busy_map <= busy_next;
      pend_cnt <= pend_next;
      if (wb_valid && pend_cnt == 3'd0) err_underflow <= 1'b1;
      if (inst_valid && !inst_ready && !flush && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl: the driver pushes the hand-computed expected outputs for each
// cycle into a queue, and a negedge monitor pops and compares them against the DUT.
module tb_id_issue_ctrl;

  localparam int W = 58;

  logic        clk, rst;
  logic        inst_valid, inst_ready;
  logic [4:0]  rs1_index, rs2_index, rd_index, wb_index;
  logic        rs1_en, rs2_en, rd_en, inst_load, inst_csr, inst_trap, inst_mret;
  logic        ex_ready, issue_valid, wb_valid, flush, err_underflow;
  logic [31:0] busy_map;
  logic [2:0]  pend_cnt;
  logic [1:0]  stall_cause, fsm_state;
  logic [15:0] stall_cycles;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  logic [15:0]  exp_stall;
  int           checks, failures;

  id_issue_ctrl #(.MAX_PEND(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rs1_en(rs1_en), .rs2_en(rs2_en),
    .rd_index(rd_index), .rd_en(rd_en), .inst_load(inst_load), .inst_csr(inst_csr),
    .inst_trap(inst_trap), .inst_mret(inst_mret), .ex_ready(ex_ready),
    .issue_valid(issue_valid), .wb_valid(wb_valid), .wb_index(wb_index), .flush(flush),
    .busy_map(busy_map), .pend_cnt(pend_cnt), .stall_cause(stall_cause),
    .stall_cycles(stall_cycles), .err_underflow(err_underflow), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ser: 0 none, 1 csr, 2 trap, 3 mret
  task automatic drive(input logic iv, input logic ld, input logic [1:0] ser,
                       input logic [4:0] rd, input logic rden,
                       input logic [4:0] r1, input logic r1en,
                       input logic [4:0] r2, input logic r2en,
                       input logic exr, input logic wbv, input logic [4:0] wbi,
                       input logic fl);
    inst_valid = iv;  inst_load = ld;
    inst_csr = (ser == 2'd1); inst_trap = (ser == 2'd2); inst_mret = (ser == 2'd3);
    rd_index = rd;   rd_en = rden;
    rs1_index = r1;  rs1_en = r1en;
    rs2_index = r2;  rs2_en = r2en;
    ex_ready = exr;  wb_valid = wbv; wb_index = wbi; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  // Expected issue_valid/cause for this cycle and state visible before the coming edge.
  task automatic expect_cycle(input string nm, input logic ev, input logic [1:0] ec,
                              input logic [31:0] eb, input logic [2:0] ep,
                              input logic [1:0] ef, input logic ee);
    logic er;
    if (!rst) exp_stall = 16'd0;
    er = ev & ex_ready;
    exp_q.push_back({ev, er, ec, eb, ep, ef, ee, exp_stall});
    name_q.push_back(nm);
    if (rst && inst_valid && !er && !flush && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [W-1:0] exp_v, act_v;
      string nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      act_v = {issue_valid, inst_ready, stall_cause, busy_map, pend_cnt, fsm_state,
               err_underflow, stall_cycles};
      checks = checks + 1;
      if (act_v !== exp_v) begin
        failures = failures + 1;
        $display("FAIL %s got=%h exp=%h (iv,rdy,cause,busy,pend,fsm,err,stall)", nm, act_v, exp_v);
      end
    end
  end

  initial begin
    checks = 0; failures = 0; exp_stall = 16'd0;
    rst = 1'b0;
    idle();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 2'd0, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    expect_cycle("reset", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    rst = 1'b1;

    // load x5, dependent use, same-cycle write-back release
    drive(1, 1, 0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t1_load", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    drive(1, 0, 0, 5'd6, 1, 5'd5, 1, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t1_raw_stall", 1'b0, 2'b01, 32'h20, 3'd1, 2'd0, 1'b0);
    drive(1, 0, 0, 5'd6, 1, 5'd5, 1, 5'd0, 0, 1, 1, 5'd5, 0);
    expect_cycle("t1_wb_issue", 1'b1, 2'b00, 32'h20, 3'd1, 2'd1, 1'b0);
    idle();
    expect_cycle("t1_after", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);

    // three loads, third hits the slot limit
    drive(1, 1, 0, 5'd1, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t2_ld1", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    drive(1, 1, 0, 5'd2, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t2_ld2", 1'b1, 2'b00, 32'h2, 3'd1, 2'd0, 1'b0);
    drive(1, 1, 0, 5'd3, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t2_ld3_full", 1'b0, 2'b11, 32'h6, 3'd2, 2'd0, 1'b0);
    drive(1, 1, 0, 5'd3, 1, 5'd0, 0, 5'd0, 0, 1, 1, 5'd1, 0);
    expect_cycle("t2_ld3_wb", 1'b1, 2'b00, 32'h6, 3'd2, 2'd1, 1'b0);
    idle();
    expect_cycle("t2_after", 1'b0, 2'b00, 32'hC, 3'd2, 2'd0, 1'b0);

    // CSR drains two loads
    drive(1, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t3_drain", 1'b0, 2'b10, 32'hC, 3'd2, 2'd0, 1'b0);
    drive(1, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd2, 0);
    expect_cycle("t3_wb1", 1'b0, 2'b10, 32'hC, 3'd2, 2'd2, 1'b0);
    drive(1, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd3, 0);
    expect_cycle("t3_wb2_issue", 1'b1, 2'b00, 32'h8, 3'd1, 2'd2, 1'b0);
    idle();
    expect_cycle("t3_after", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);

    // load to x0
    drive(1, 1, 0, 5'd0, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t4_ld_x0", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd0, 0);
    expect_cycle("t4_wb_x0", 1'b0, 2'b00, 32'h0, 3'd1, 2'd0, 1'b0);
    idle();
    expect_cycle("t4_after", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);

    // stall on x7, flush, then underflow
    drive(1, 1, 0, 5'd7, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t5_ld_x7", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    drive(1, 0, 0, 5'd8, 1, 5'd0, 0, 5'd7, 1, 1, 0, 5'd0, 0);
    expect_cycle("t5_stall", 1'b0, 2'b01, 32'h80, 3'd1, 2'd0, 1'b0);
    drive(1, 0, 0, 5'd8, 1, 5'd0, 0, 5'd7, 1, 1, 0, 5'd0, 1);
    expect_cycle("t5_flush", 1'b0, 2'b00, 32'h80, 3'd1, 2'd1, 1'b0);
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd7, 0);
    expect_cycle("t5_post_flush_wb", 1'b0, 2'b00, 32'h80, 3'd1, 2'd0, 1'b0);
    drive(0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 1, 5'd9, 0);
    expect_cycle("t5_underflow_wb", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    idle();
    expect_cycle("t5_err_sticky", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b1);

    // reset while draining (trap then mret as the serialising instruction)
    drive(1, 1, 0, 5'd10, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t6_ld10", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b1);
    drive(1, 1, 0, 5'd11, 1, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t6_ld11", 1'b1, 2'b00, 32'h400, 3'd1, 2'd0, 1'b1);
    drive(1, 0, 2, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t6_trap_drain", 1'b0, 2'b10, 32'hC00, 3'd2, 2'd0, 1'b1);
    drive(1, 0, 3, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 0, 5'd0, 0);
    expect_cycle("t6_mret_drain", 1'b0, 2'b10, 32'hC00, 3'd2, 2'd2, 1'b1);
    rst = 1'b0;
    expect_cycle("t6_reset_async", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    expect_cycle("t6_reset_hold", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    rst = 1'b1;
    expect_cycle("t6_release", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);

    // ex_ready low without a hazard: counted, but no FSM change
    drive(1, 0, 0, 5'd4, 1, 5'd1, 1, 5'd2, 1, 0, 0, 5'd0, 0);
    expect_cycle("t7_ex_busy", 1'b1, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);
    idle();
    expect_cycle("t7_after", 1'b0, 2'b00, 32'h0, 3'd0, 2'd0, 1'b0);

    @(negedge clk);
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
